// File: rtl/lnl_io_ctrl.sv
// Keyboard/display I/O controller: synchronised key strobe feeding a FWFT input FIFO,
// plus a display register with a fixed-length busy window after each accepted OUT.
module lnl_io_ctrl #(
  parameter int DW       = 8,
  parameter int DEPTH    = 4,
  parameter int SYNC     = 2,
  parameter int OUT_BUSY = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DW-1:0]                kbd_data,
  input  logic                         kbd_strobe,
  input  logic                         inp_rd,
  output logic [DW-1:0]                inp_data,
  output logic                         fgi,
  input  logic                         out_wr,
  input  logic [DW-1:0]                out_wdata,
  output logic [DW-1:0]                disp,
  output logic                         fgo,
  input  logic                         ien,
  output logic                         irq,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         ovf,
  input  logic                         ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(OUT_BUSY + 1);

  // ---------------------------------------------------------------- strobe path
  // Chain and edge flop reset high so a strobe held through reset release is not a key.
  logic [SYNC-1:0] sync_reg;
  logic            prev_reg;
  logic            push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '1;
      prev_reg <= 1'b1;
    end else begin
      sync_reg <= {sync_reg[SYNC-2:0], kbd_strobe};
      prev_reg <= sync_reg[SYNC-1];
    end
  end

  assign push = sync_reg[SYNC-1] & ~prev_reg;

  // ---------------------------------------------------------------- input FIFO
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [DW-1:0] head_reg, head_next;
  logic          ovf_reg;
  logic          empty, full, pop_ok, wr_en, ovf_set;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop_ok  = inp_rd & ~empty;
  // A pop frees the slot, so a push into a full FIFO still lands when paired with a pop.
  assign wr_en   = push & (~full | pop_ok);
  assign ovf_set = push & full & ~pop_ok;

  always_comb begin
    rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, pop_ok};
    wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, wr_en};
    head_next   = '0;
    if (rd_ptr_next != wr_ptr_next) begin
      // New head is the word being written this cycle: bypass the storage array.
      if (wr_en && (rd_ptr_next == wr_ptr_reg))
        head_next = kbd_data;
      else
        head_next = mem[rd_ptr_next[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr_reg[AW-1:0]] <= kbd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      head_reg   <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      head_reg   <= head_next;
      if (ovf_set)
        ovf_reg <= 1'b1;
      else if (ovf_clr)
        ovf_reg <= 1'b0;
    end
  end

  assign inp_data = head_reg;
  assign fgi      = ~empty;
  assign level    = LW'(wr_ptr_reg - rd_ptr_reg);
  assign ovf      = ovf_reg;

  // ---------------------------------------------------------------- output path
  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_WAIT = 1'b1
  } out_state_t;

  out_state_t    out_state_reg;
  logic [CW-1:0] busy_cnt_reg;
  logic [DW-1:0] disp_reg;
  logic          fgo_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_state_reg <= OUT_IDLE;
      busy_cnt_reg  <= '0;
      disp_reg      <= '0;
      fgo_reg       <= 1'b1;
    end else begin
      case (out_state_reg)
        OUT_IDLE: begin
          if (out_wr) begin
            disp_reg      <= out_wdata;
            fgo_reg       <= 1'b0;
            busy_cnt_reg  <= CW'(OUT_BUSY);
            out_state_reg <= OUT_WAIT;
          end
        end
        OUT_WAIT: begin
          // Writes during the busy window are dropped; fgo returns on the 1->0 step.
          busy_cnt_reg <= busy_cnt_reg - CW'(1);
          if (busy_cnt_reg == CW'(1)) begin
            fgo_reg       <= 1'b1;
            out_state_reg <= OUT_IDLE;
          end
        end
        default: begin
          out_state_reg <= OUT_IDLE;
          fgo_reg       <= 1'b1;
          busy_cnt_reg  <= '0;
        end
      endcase
    end
  end

  assign disp = disp_reg;
  assign fgo  = fgo_reg;
  assign irq  = ien & (fgi | fgo);

endmodule

// File: tb/tb_lnl_io_ctrl.sv
// Self-checking bench for lnl_io_ctrl: vector table for FIFO fill/drain,
// queue scoreboard for key ordering, hand sequences for timing corners.
module tb_lnl_io_ctrl;
  localparam int DW = 8, DEPTH = 4, SYNC = 2, OUT_BUSY = 4;
  localparam int LW = $clog2(DEPTH + 1);

  logic          clk, rst_n;
  logic [DW-1:0] kbd_data, inp_data, out_wdata, disp;
  logic          kbd_strobe, inp_rd, fgi, out_wr, fgo, ien, irq, ovf, ovf_clr;
  logic [LW-1:0] level;

  lnl_io_ctrl #(.DW(DW), .DEPTH(DEPTH), .SYNC(SYNC), .OUT_BUSY(OUT_BUSY)) dut (
    .clk(clk), .rst_n(rst_n), .kbd_data(kbd_data), .kbd_strobe(kbd_strobe),
    .inp_rd(inp_rd), .inp_data(inp_data), .fgi(fgi), .out_wr(out_wr),
    .out_wdata(out_wdata), .disp(disp), .fgo(fgo), .ien(ien), .irq(irq),
    .level(level), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  bit m_ovf = 1'b0;
  bit m_fgo = 1'b1;

  typedef enum int {OP_KEY, OP_KPOP, OP_POP, OP_CLR} op_t;
  typedef struct {
    op_t        op;
    logic [7:0] data;
    int         exp_level;
    bit         exp_ovf;
  } vec_t;
  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    bit         mf;
    logic [7:0] eh;
    mf = (sb.size() != 0);
    eh = mf ? sb[0] : 8'h00;
    chk({tag, " level"}, 32'(level), 32'(sb.size()));
    chk({tag, " fgi"}, 32'(fgi), 32'(mf));
    chk({tag, " inp_data"}, 32'(inp_data), 32'(eh));
    chk({tag, " ovf"}, 32'(ovf), 32'(m_ovf));
    chk({tag, " fgo"}, 32'(fgo), 32'(m_fgo));
    chk({tag, " irq"}, 32'(irq), 32'(ien & (mf | m_fgo)));
  endtask

  // One key stroke; optionally pulses inp_rd so it coincides with the push edge.
  task automatic key(input logic [7:0] d, input bit pop_at_push);
    kbd_data   = d;
    kbd_strobe = 1'b1;
    tick();
    tick();
    if (pop_at_push) begin
      chk("kpop head", 32'(inp_data), 32'((sb.size() != 0) ? sb[0] : 8'h00));
      inp_rd = 1'b1;
    end
    tick();
    inp_rd = 1'b0;
    if (pop_at_push && sb.size() != 0) void'(sb.pop_front());
    if (sb.size() < DEPTH) sb.push_back(d);
    else m_ovf = 1'b1;
    tick();
    kbd_strobe = 1'b0;
    repeat (3) tick();
    $display("key %h pop %0d level %0d ovf %0d head %h", d, pop_at_push, level, ovf, inp_data);
  endtask

  task automatic pop();
    logic [7:0] eh;
    eh = (sb.size() != 0) ? sb[0] : 8'h00;
    chk("pop data", 32'(inp_data), 32'(eh));
    $display("pop %h level %0d", inp_data, level);
    inp_rd = 1'b1;
    tick();
    inp_rd = 1'b0;
    if (sb.size() != 0) void'(sb.pop_front());
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{OP_KEY,  8'h11, 1, 1'b0};
    vecs[1]  = '{OP_KEY,  8'h22, 2, 1'b0};
    vecs[2]  = '{OP_KEY,  8'h33, 3, 1'b0};
    vecs[3]  = '{OP_KEY,  8'h44, 4, 1'b0};
    vecs[4]  = '{OP_KEY,  8'h55, 4, 1'b1};
    vecs[5]  = '{OP_POP,  8'h00, 3, 1'b1};
    vecs[6]  = '{OP_POP,  8'h00, 2, 1'b1};
    vecs[7]  = '{OP_POP,  8'h00, 1, 1'b1};
    vecs[8]  = '{OP_POP,  8'h00, 0, 1'b1};
    vecs[9]  = '{OP_CLR,  8'h00, 0, 1'b0};
    vecs[10] = '{OP_KEY,  8'hA1, 1, 1'b0};
    vecs[11] = '{OP_KEY,  8'hA2, 2, 1'b0};
    vecs[12] = '{OP_KEY,  8'hA3, 3, 1'b0};
    vecs[13] = '{OP_KEY,  8'hA4, 4, 1'b0};
    vecs[14] = '{OP_KPOP, 8'hB1, 4, 1'b0};
    vecs[15] = '{OP_POP,  8'h00, 3, 1'b0};
    vecs[16] = '{OP_POP,  8'h00, 2, 1'b0};
    vecs[17] = '{OP_POP,  8'h00, 1, 1'b0};
    vecs[18] = '{OP_POP,  8'h00, 0, 1'b0};
    vecs[19] = '{OP_POP,  8'h00, 0, 1'b0};

    rst_n = 1'b1; kbd_strobe = 1'b1; kbd_data = '0; inp_rd = 1'b0;
    out_wr = 1'b0; out_wdata = '0; ien = 1'b1; ovf_clr = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    check_state("in_reset");
    chk("in_reset disp", 32'(disp), 32'h0);

    // Strobe held high through reset release must not produce a key.
    rst_n = 1'b1;
    repeat (20) tick();
    check_state("idle");
    chk("idle disp", 32'(disp), 32'h0);
    ien = 1'b0; #1;
    chk("irq ien0", 32'(irq), 32'h0);
    ien = 1'b1;
    kbd_strobe = 1'b0;
    repeat (3) tick();

    // Single key with exact push latency.
    kbd_data = 8'h77; kbd_strobe = 1'b1;
    tick();
    tick();
    chk("latency fgi early", 32'(fgi), 32'h0);
    tick();
    sb.push_back(8'h77);
    check_state("single");
    tick();
    kbd_strobe = 1'b0;
    repeat (3) tick();
    pop();
    check_state("single_popped");

    for (int i = 0; i < 20; i++) begin
      case (vecs[i].op)
        OP_KEY:  key(vecs[i].data, 1'b0);
        OP_KPOP: key(vecs[i].data, 1'b1);
        OP_POP:  pop();
        default: begin
          ovf_clr = 1'b1;
          tick();
          ovf_clr = 1'b0;
          m_ovf = 1'b0;
        end
      endcase
      chk($sformatf("vec%0d level", i), 32'(level), 32'(vecs[i].exp_level));
      chk($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
      check_state($sformatf("vec%0d", i));
    end

    // Three wrap-around passes, order preserved.
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < DEPTH; k++) key(8'(8'hC0 + p * 16 + k), 1'b0);
      check_state($sformatf("wrap%0d full", p));
      for (int k = 0; k < DEPTH; k++) pop();
      check_state($sformatf("wrap%0d empty", p));
    end

    // Output busy window and ignored write.
    out_wdata = 8'h66; out_wr = 1'b1;
    tick();
    out_wr = 1'b0;
    chk("out disp", 32'(disp), 32'h66);
    chk("out fgo m", 32'(fgo), 32'h0);
    tick();
    chk("out fgo m1", 32'(fgo), 32'h0);
    out_wdata = 8'h99; out_wr = 1'b1;
    tick();
    out_wr = 1'b0;
    chk("busy write ignored", 32'(disp), 32'h66);
    chk("out fgo m2", 32'(fgo), 32'h0);
    tick();
    chk("out fgo m3", 32'(fgo), 32'h0);
    chk("irq busy", 32'(irq), 32'h0);
    tick();
    chk("out fgo m4", 32'(fgo), 32'h1);
    $display("out 66 disp %h fgo %0d", disp, fgo);
    out_wr = 1'b1;
    tick();
    out_wr = 1'b0;
    chk("out2 disp", 32'(disp), 32'h99);
    chk("out2 fgo", 32'(fgo), 32'h0);
    repeat (OUT_BUSY) tick();
    chk("out2 fgo back", 32'(fgo), 32'h1);
    $display("out 99 disp %h fgo %0d", disp, fgo);

    // Mid-operation asynchronous reset.
    key(8'h01, 1'b0); key(8'h02, 1'b0); key(8'h03, 1'b0);
    out_wdata = 8'h5A; out_wr = 1'b1;
    tick();
    out_wr = 1'b0;
    chk("pre_rst level", 32'(level), 32'h3);
    chk("pre_rst fgo", 32'(fgo), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    sb.delete(); m_ovf = 1'b0; m_fgo = 1'b1;
    check_state("async_rst");
    chk("async_rst disp", 32'(disp), 32'h0);
    $display("async reset level %0d fgo %0d disp %h", level, fgo, disp);
    #1 rst_n = 1'b1;
    repeat (2) tick();
    check_state("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lnl_io_ctrl.md
# lnl_io_ctrl

Parametrised keyboard/display I/O controller for the LnL SoC: the next generation of the single-register FGI/FGO input/output pair. Key strobes on the asynchronous interrupt pin are synchronised and captured into a DEPTH-entry input FIFO. CPU INP and OUT micro-operations drain that FIFO and load a display register with a programmable busy window. The block sits between `tt_um_LnL_SoC` pads (`ui_in`, `uio_in[0]`, `uo_out`) and `cpu0`, supplying FGI, FGO and the interrupt request.

## Interface
- `DW`, 8: data width of keyboard, INP, OUT and display paths.
- `DEPTH`, 4: input FIFO entries; power of two, ≥2.
- `SYNC`, 2: synchroniser stages on `kbd_strobe`; ≥2.
- `OUT_BUSY`, 4: cycles FGO stays low after an accepted OUT; ≥1.

- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `kbd_data`  in  DW  keyboard byte (`ui_in`).
- `kbd_strobe`  in  1  asynchronous key strobe (`uio_in[0]`); rising edge = new key.
- `inp_rd`  in  1  CPU INP pulse; pops FIFO head.
- `inp_data`  out  DW  FIFO head (first-word-fall-through); 0 when empty.
- `fgi`  out  1  input flag = FIFO non-empty.
- `out_wr`  in  1  CPU OUT pulse.
- `out_wdata`  in  DW  byte to display (AC[DW-1:0]).
- `disp`  out  DW  display register (`uo_out`).
- `fgo`  out  1  output-ready flag.
- `ien`  in  1  CPU interrupt enable.
- `irq`  out  1  `ien & (fgi | fgo)`, combinational.
- `level`  out  $clog2(DEPTH+1)  FIFO occupancy.
- `ovf`  out  1  sticky overflow flag.
- `ovf_clr`  in  1  clears `ovf`.

## Operation
- Strobe path: `SYNC`-flop chain, then a `prev` flop; `push = sync_last & ~prev`. On reset, chain and `prev` are set to 1, so a strobe held high through reset release produces no push. One push occurs per rising edge, whatever the pulse width.
- `kbd_data` is sampled at the push edge and must be stable for `SYNC`+1 cycles after strobe rise.
- FIFO: `wr_ptr`/`rd_ptr` are log2(DEPTH)+1 bits wide; full/empty are decided by MSB compare; both pointers wrap modulo 2·DEPTH.
  - Push, not full: store and increment `wr_ptr`.
  - Push when full with no pop: data dropped, `ovf` set.
  - Pop (`inp_rd`) when empty: ignored; no pointer change, no flag change.
  - Push and pop in the same cycle, non-empty: both occur, `level` unchanged, no overflow. This also holds when full.
  - Push and pop in the same cycle, empty: push only.
- `ovf`: set has priority over `ovf_clr` in the same cycle.
- Output path:
  - `out_wr` with `fgo`=1: `disp` <= `out_wdata`, `fgo` <= 0, busy counter <= `OUT_BUSY`.
  - Counter decrements each cycle. `fgo` <= 1 on the edge where the counter goes 1→0.
  - `out_wr` with `fgo`=0: ignored; `disp` and counter unchanged.
- Reset values: `inp_data`=0, `fgi`=0, `level`=0, `ovf`=0, `disp`=0, `fgo`=1, counter=0, pointers=0, FIFO storage not reset. `irq` = `ien` after reset, because `fgo`=1.
- Reset asserted mid-operation: FIFO contents are discarded (pointers to 0) and any busy window is aborted (`fgo`=1) asynchronously.

## Timing
- Push latency: strobe high with setup before edge n gives the push at edge n+`SYNC`; `fgi`, `level` and `inp_data` update after that edge.
- `inp_rd` at edge p: `inp_data` shows the next entry, or 0 if none, after edge p. `fgi` falls after p if the FIFO is now empty.
- OUT accepted at edge m: `fgo`=0 from after m until edge m+`OUT_BUSY`, i.e. exactly `OUT_BUSY` cycles low. `disp` is valid after m.
- All outputs except `irq` are registered or decoded from registers; there are no combinational paths from pads to CPU.

## Test plan
- Reset/idle: hold `rst_n`=0, strobe=1; release → no push for 20 cycles; `fgi`=0, `fgo`=1, `disp`=00, `irq`=`ien`.
- Single key: `kbd_data`=77, strobe high 4 cycles → after edge n+2: `fgi`=1, `level`=1, `inp_data`=77. `inp_rd` pulse → `fgi`=0, `inp_data`=00.
- Fill/overflow (DEPTH=4): keys 11,22,33,44,55 → `level`=4, `ovf`=1. Four pops return 11,22,33,44 in order. `ovf_clr` → `ovf`=0.
- Simultaneous push+pop when full: `level` stays 4, `ovf` stays 0, head advances. Pop on empty → no change; then run 3 full wrap-around passes of 4 keys with order preserved.
- Output busy: `out_wr`, `out_wdata`=66 → `disp`=66, `fgo` low 4 cycles. A second `out_wr` of 99 during busy is ignored (`disp` stays 66); accepted once `fgo`=1.
- Mid-operation reset: 3 keys queued plus OUT busy; pulse `rst_n` low asynchronously (no clock edge) → `level`=0, `fgi`=0, `fgo`=1, `disp`=00 immediately.
